// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: branch funct3 codes, jump and PC-select encodings,
// and the 2-bit predictor counter type with its helpers.
package pipe_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    typedef enum logic [1:0] {
        PCSRC_SEQ  = 2'b00,
        PCSRC_TGT  = 2'b01,
        PCSRC_JALR = 2'b10,
        PCSRC_FALL = 2'b11
    } pc_src_e;

    typedef logic [1:0] ctr2_t;
    localparam ctr2_t CTR_WNT = 2'b01;

    typedef struct packed {
        logic legal;
        logic taken;
    } br_cond_t;

    function automatic br_cond_t resolve_cond(input logic [2:0] funct3, input logic zero,
                                              input logic lt, input logic ltu);
        br_cond_t r;
        r.legal = 1'b1;
        case (funct3)
            BR_BEQ:  r.taken = zero;
            BR_BNE:  r.taken = ~zero;
            BR_BLT:  r.taken = lt;
            BR_BGE:  r.taken = ~lt;
            BR_BLTU: r.taken = ltu;
            BR_BGEU: r.taken = ~ltu;
            default: begin
                r.legal = 1'b0;
                r.taken = 1'b0;
            end
        endcase
        return r;
    endfunction

    function automatic ctr2_t ctr_next(input ctr2_t c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with a write-first bypass
// so a lookup that hits the index being trained sees the updated direction.
module bht_2bit
    import pipe_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    ctr2_t ctr_q [DEPTH];
    ctr2_t upd_next;

    assign upd_next = ctr_next(ctr_q[upd_idx], upd_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is built from resettable flops, not a RAM, because every
            // entry must snap back to weakly-not-taken the instant reset asserts.
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_WNT;
        end else if (upd_en) begin
            // NOTE: non-blocking so every reader in this cycle sees the pre-edge value.
            ctr_q[upd_idx] <= upd_next;
        end
    end

    always_comb begin
        rd_taken = ctr_q[rd_idx][1];
        if (upd_en && (upd_idx == rd_idx)) rd_taken = upd_next[1];
    end

endmodule

// File: rtl/pipeline_branch_unit.sv
// MEM-stage branch/jump resolution, redirect/flush generation and BHT training.
// Optional performance counters are built when PIPE_BU_PERF_CNT_EN is defined.
module pipeline_branch_unit
    import pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              mem_valid,
    input  logic              mem_stall,
    input  logic [XLEN-1:0]   mem_pc,
    input  logic              mem_branch,
    input  logic [2:0]        mem_funct3,
    input  logic [1:0]        mem_jump,
    input  logic              mem_zero,
    input  logic              mem_lt,
    input  logic              mem_ltu,
    input  logic              mem_pred_taken,
    input  logic [XLEN-1:0]   mem_target,
    input  logic [XLEN-1:0]   mem_jalr_target,
    output logic [1:0]        pc_src,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispred
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic     act;
    logic     is_jal;
    logic     is_jalr;
    logic     train;
    br_cond_t cond;
    pc_src_e  src;

    // Reset is folded in so no redirect can leak out while rst_n is low.
    assign act     = mem_valid & ~mem_stall & rst_n;
    assign is_jal  = (mem_jump == JMP_JAL);
    assign is_jalr = (mem_jump == JMP_JALR);
    assign cond    = resolve_cond(mem_funct3, mem_zero, mem_lt, mem_ltu);
    assign train   = act & mem_branch & cond.legal & ~is_jal & ~is_jalr;

    always_comb begin
        // NOTE: default assigned first so every path writes src and no latch is inferred.
        src = PCSRC_SEQ;
        if (act) begin
            if (is_jalr)                                          src = PCSRC_JALR;
            else if (is_jal && !mem_pred_taken)                   src = PCSRC_TGT;
            else if (mem_branch && cond.taken && !mem_pred_taken) src = PCSRC_TGT;
            else if (mem_branch && !cond.taken && mem_pred_taken) src = PCSRC_FALL;
        end
    end

    always_comb begin
        case (src)
            PCSRC_TGT:  redirect_pc = mem_target;
            PCSRC_JALR: redirect_pc = mem_jalr_target;
            PCSRC_FALL: redirect_pc = mem_pc + XLEN'(4);
            default:    redirect_pc = '0;
        endcase
    end

    assign pc_src = src;
    assign flush  = (src != PCSRC_SEQ);

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_taken  (if_pred_taken),
        .upd_en    (train),
        .upd_idx   (mem_pc[IDX_W+1:2]),
        .upd_taken (cond.taken)
    );

    // Only the index bits of the fetch PC address the table.
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

`ifdef PIPE_BU_PERF_CNT_EN
    logic [PERF_W-1:0] br_cnt_q;
    logic [PERF_W-1:0] mis_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (act && (mem_branch || is_jal || is_jalr) && !(&br_cnt_q))
                br_cnt_q <= br_cnt_q + PERF_W'(1);
            if (flush && !(&mis_cnt_q))
                mis_cnt_q <= mis_cnt_q + PERF_W'(1);
        end
    end

    assign perf_branches = br_cnt_q;
    assign perf_mispred  = mis_cnt_q;
`else
    assign perf_branches = '0;
    assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_pipeline_branch_unit.sv
// Self-checking bench for pipeline_branch_unit: directed scenarios plus random
// traffic, all compared every cycle against an integer-counter reference model.
module tb_pipeline_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        mem_valid;
    logic        mem_stall;
    logic [31:0] mem_pc;
    logic        mem_branch;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_jump;
    logic        mem_zero;
    logic        mem_lt;
    logic        mem_ltu;
    logic        mem_pred_taken;
    logic [31:0] mem_target;
    logic [31:0] mem_jalr_target;
    logic [1:0]  pc_src;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispred;

    pipeline_branch_unit #(.XLEN(32), .BHT_DEPTH(64), .PERF_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .if_pred_taken   (if_pred_taken),
        .mem_valid       (mem_valid),
        .mem_stall       (mem_stall),
        .mem_pc          (mem_pc),
        .mem_branch      (mem_branch),
        .mem_funct3      (mem_funct3),
        .mem_jump        (mem_jump),
        .mem_zero        (mem_zero),
        .mem_lt          (mem_lt),
        .mem_ltu         (mem_ltu),
        .mem_pred_taken  (mem_pred_taken),
        .mem_target      (mem_target),
        .mem_jalr_target (mem_jalr_target),
        .pc_src          (pc_src),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .perf_branches   (perf_branches),
        .perf_mispred    (perf_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: one integer 0..3 per table entry, plus event counts.
    int      bht_m [64];
    longint  perf_b_m;
    longint  perf_m_m;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit m_legal(input logic [2:0] f3);
        return !(f3 == 3'd2 || f3 == 3'd3);
    endfunction

    function automatic bit m_taken(input logic [2:0] f3, input bit z, input bit lt, input bit ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        perf_b_m = 0;
        perf_m_m = 0;
    endtask

    // Computes what the outputs must be from the current inputs and model state.
    task automatic model_eval(output int e_src, output logic [31:0] e_rpc, output bit e_pred,
                              output bit trains, output bit tk);
        bit act;
        int post;
        act    = (mem_valid === 1'b1) && (mem_stall === 1'b0) && (rst_n === 1'b1);
        tk     = m_taken(mem_funct3, mem_zero, mem_lt, mem_ltu);
        e_src  = 0;
        if (act) begin
            if (mem_jump == 2'd2)                          e_src = 2;
            else if (mem_jump == 2'd1 && !mem_pred_taken)  e_src = 1;
            else if (mem_branch && tk && !mem_pred_taken)  e_src = 1;
            else if (mem_branch && !tk && mem_pred_taken)  e_src = 3;
        end
        case (e_src)
            1:       e_rpc = mem_target;
            2:       e_rpc = mem_jalr_target;
            3:       e_rpc = mem_pc + 32'd4;
            default: e_rpc = 32'd0;
        endcase
        trains = act && mem_branch && m_legal(mem_funct3) && (mem_jump == 2'd0 || mem_jump == 2'd3);
        post   = bht_m[idx_of(mem_pc)];
        if (trains) post = tk ? ((post < 3) ? post + 1 : 3) : ((post > 0) ? post - 1 : 0);
        if (trains && idx_of(if_pc) == idx_of(mem_pc)) e_pred = (post >= 2);
        else e_pred = (bht_m[idx_of(if_pc)] >= 2);
    endtask

    // Compare process body: runs at the falling edge, away from the sampling edge.
    task automatic settle();
        int e_src; logic [31:0] e_rpc; bit e_pred, tr, tk;
        @(negedge clk);
        model_eval(e_src, e_rpc, e_pred, tr, tk);
        check("pc_src", 64'(pc_src), 64'(e_src));
        check("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
        check("flush", 64'(flush), 64'(e_src != 0));
        check("if_pred_taken", 64'(if_pred_taken), 64'(e_pred));
`ifdef PIPE_BU_PERF_CNT_EN
        check("perf_branches", 64'(perf_branches), 64'(perf_b_m));
        check("perf_mispred", 64'(perf_mispred), 64'(perf_m_m));
`else
        check("perf_branches", 64'(perf_branches), 64'd0);
        check("perf_mispred", 64'(perf_mispred), 64'd0);
`endif
    endtask

    task automatic advance();
        int e_src; logic [31:0] e_rpc; bit e_pred, tr, tk; int i;
        model_eval(e_src, e_rpc, e_pred, tr, tk);
        if (rst_n === 1'b1) begin
            i = idx_of(mem_pc);
            if (tr) bht_m[i] = tk ? ((bht_m[i] < 3) ? bht_m[i] + 1 : 3) : ((bht_m[i] > 0) ? bht_m[i] - 1 : 0);
            if (mem_valid && !mem_stall && (mem_branch || mem_jump == 2'd1 || mem_jump == 2'd2))
                perf_b_m = (perf_b_m < 64'hFFFF_FFFF) ? perf_b_m + 1 : perf_b_m;
            if (e_src != 0)
                perf_m_m = (perf_m_m < 64'hFFFF_FFFF) ? perf_m_m + 1 : perf_m_m;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 0; mem_stall = 0; mem_branch = 0; mem_jump = 2'd0; mem_funct3 = 3'd0;
        mem_zero = 0; mem_lt = 0; mem_ltu = 0; mem_pred_taken = 0;
        mem_pc = 32'd0; mem_target = 32'd0; mem_jalr_target = 32'd0;
    endtask

    task automatic set_br(input logic [31:0] pc, input logic [2:0] f3, input bit z, input bit lt,
                          input bit ltu, input bit pred, input logic [31:0] tgt);
        mem_valid = 1; mem_stall = 0; mem_branch = 1; mem_jump = 2'd0;
        mem_pc = pc; mem_funct3 = f3; mem_zero = z; mem_lt = lt; mem_ltu = ltu;
        mem_pred_taken = pred; mem_target = tgt; mem_jalr_target = 32'h0000_0F00;
    endtask

    initial begin
        rst_n = 0;
        if_pc = 32'd0;
        idle();
        model_reset();
        settle(); advance();
        settle(); advance();
        rst_n = 1;

        // 1: cold lookup, then three taken beq at 0x40 (entry 01 -> 10 -> 11 -> 11).
        if_pc = 32'h40;
        settle();
        check("t1_cold_pred", 64'(if_pred_taken), 64'd0);
        advance();
        if_pc = 32'h44;
        for (int k = 0; k < 3; k++) begin
            set_br(32'h40, 3'b000, 1, 0, 0, (k != 0), 32'h1000);
            settle();
            check("t1_pc_src", 64'(pc_src), (k == 0) ? 64'd1 : 64'd0);
            check("t1_redirect", 64'(redirect_pc), (k == 0) ? 64'h1000 : 64'd0);
            advance();
        end
        idle(); if_pc = 32'h40;
        settle();
        check("t1_trained_pred", 64'(if_pred_taken), 64'd1);
        advance();

        // 2: bne at 0x80 trained to 10, then mispredicted not-taken.
        set_br(32'h80, 3'b001, 0, 0, 0, 0, 32'h2000);
        settle(); advance();
        set_br(32'h80, 3'b001, 1, 0, 0, 1, 32'h2000); if_pc = 32'h80;
        settle();
        check("t2_pc_src", 64'(pc_src), 64'd3);
        check("t2_redirect", 64'(redirect_pc), 64'h84);
        check("t2_flush", 64'(flush), 64'd1);
        check("t2_pred_bypass", 64'(if_pred_taken), 64'd0);
        advance();

        // 3: jalr with pred=1 always redirects and leaves the table alone.
        idle(); mem_valid = 1; mem_pc = 32'h80; mem_jump = 2'd2; mem_pred_taken = 1;
        mem_jalr_target = 32'h1234;
        settle();
        check("t3_pc_src", 64'(pc_src), 64'd2);
        check("t3_redirect", 64'(redirect_pc), 64'h1234);
        advance();
        idle();
        settle();
        check("t3_bht_unchanged", 64'(if_pred_taken), 64'd0);
        advance();

        // 4: taken blt held by a 3-cycle stall, resolving once afterwards.
        set_br(32'hC0, 3'b100, 0, 1, 0, 0, 32'h3000); if_pc = 32'hC0; mem_stall = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("t4_stall_pc_src", 64'(pc_src), 64'd0);
            check("t4_stall_pred", 64'(if_pred_taken), 64'd0);
            advance();
        end
        mem_stall = 0;
        settle();
        check("t4_resolve_pc_src", 64'(pc_src), 64'd1);
        advance();
        idle();
        settle();
        check("t4_once", 64'(pc_src), 64'd0);
        advance();

        // 5: write-first bypass on index 5.
        set_br(32'h14, 3'b111, 0, 0, 0, 0, 32'h4000); if_pc = 32'h14;
        settle();
        check("t5_bypass", 64'(if_pred_taken), 64'd1);
        advance();

        // 6: ten branches, four mispredicted, then asynchronous reset mid-run.
        idle(); rst_n = 0; model_reset();
        settle(); advance();
        rst_n = 1;
        for (int k = 0; k < 10; k++) begin
            set_br(32'h100 + 32'(k * 4), 3'b000, (k < 4), 0, 0, 0, 32'h5000);
            settle(); advance();
        end
        idle();
        settle();
`ifdef PIPE_BU_PERF_CNT_EN
        check("t6_perf_branches", 64'(perf_branches), 64'd10);
        check("t6_perf_mispred", 64'(perf_mispred), 64'd4);
`else
        check("t6_perf_branches", 64'(perf_branches), 64'd0);
        check("t6_perf_mispred", 64'(perf_mispred), 64'd0);
`endif
        advance();
        set_br(32'h100, 3'b000, 1, 0, 0, 0, 32'h5000);
        rst_n = 0; model_reset();
        settle();
        check("t6_rst_pc_src", 64'(pc_src), 64'd0);
        check("t6_rst_perf", 64'(perf_branches), 64'd0);
        advance();
        rst_n = 1; idle();
        for (int k = 0; k < 64; k++) begin
            if_pc = 32'(k * 4);
            settle();
            if (k < 4) check("t6_entry_cleared", 64'(if_pred_taken), 64'd0);
            advance();
        end
        set_br(32'h100, 3'b000, 1, 0, 0, 0, 32'h5000); if_pc = 32'h100;
        settle();
        check("t6_entry_is_wnt", 64'(if_pred_taken), 64'd1);
        advance();

        // Random traffic over a handful of table indices.
        for (int n = 0; n < 3000; n++) begin
            int r;
            if (n == 1500) begin
                idle(); rst_n = 0; model_reset();
                settle(); advance();
                rst_n = 1;
            end
            mem_valid  = ($urandom_range(0, 9) != 0);
            mem_stall  = ($urandom_range(0, 4) == 0);
            mem_pc     = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
            if_pc      = ($urandom_range(0, 2) == 0) ? mem_pc
                       : (($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2));
            r          = int'($urandom_range(0, 7));
            mem_jump   = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : (r == 2) ? 2'd3 : 2'd0;
            mem_branch = (mem_jump == 2'd1 || mem_jump == 2'd2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            mem_funct3 = 3'($urandom);
            mem_zero   = 1'($urandom);
            mem_lt     = 1'($urandom);
            mem_ltu    = 1'($urandom);
            mem_pred_taken = ($urandom_range(0, 9) < 7) ? (bht_m[idx_of(mem_pc)] >= 2) : 1'($urandom);
            mem_target      = $urandom;
            mem_jalr_target = $urandom & 32'hFFFF_FFFE;
            settle(); advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
